display_scan_driver: RTL and testbench

- Consumes the slow square wave from the 16-stage frequency divider (`divclock`, clk/65536) and drives a multiplexed common-anode 7-segment display.
- `divclock` is not used as a clock. It is synchronised into the `clk` domain and edge-detected, and each rising edge advances the scanned digit.
- A short all-off blanking interval is inserted between digits to suppress ghosting.
- Sits between the divider and the board display pins.

---
 rtl/display_scan_driver_if.sv | 26 ++
 rtl/display_scan_driver.sv | 110 +++++++++++
 tb/tb_display_scan_driver.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - divider input, digit data and display pin bundle
// master drives divclock/enable/digit data; slave (the driver) drives the pins.
interface display_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
);
  logic                    divclock;
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    scan_tick;

  modport master (
    output divclock, enable, digits, dp_mask,
    input  an, seg, dp, digit_idx, scan_tick
  );

  modport slave (
    input  divclock, enable, digits, dp_mask,
    output an, seg, dp, digit_idx, scan_tick
  );
endinterface

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - multiplexed common-anode 7-segment scan driver
// divclock is sampled as data; each rising edge in SHOW moves to the next digit via a blanking gap.
module display_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = 2
) (
  input logic                  clk,
  input logic                  reset,
  display_scan_driver_if.slave bus
);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t             state;
  logic [BW-1:0]      bcnt;
  logic [IDX_W-1:0]   idx;
  logic               s1, s2, s3;
  logic               tick;
  logic               rise;
  logic [3:0]         nib;
  logic [NUM_DIGITS-1:0] an_c;
  logic [6:0]         seg_c;
  logic               dp_c;

  function automatic logic [6:0] hexdecode(input logic [3:0] h);
    case (h)
      4'h0: hexdecode = 7'b1000000;
      4'h1: hexdecode = 7'b1111001;
      4'h2: hexdecode = 7'b0100100;
      4'h3: hexdecode = 7'b0110000;
      4'h4: hexdecode = 7'b0011001;
      4'h5: hexdecode = 7'b0010010;
      4'h6: hexdecode = 7'b0000010;
      4'h7: hexdecode = 7'b1111000;
      4'h8: hexdecode = 7'b0000000;
      4'h9: hexdecode = 7'b0010000;
      4'hA: hexdecode = 7'b0001000;
      4'hB: hexdecode = 7'b0000011;
      4'hC: hexdecode = 7'b1000110;
      4'hD: hexdecode = 7'b0100001;
      4'hE: hexdecode = 7'b0000110;
      default: hexdecode = 7'b0001110;
    endcase
  endfunction

  assign rise = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      bcnt  <= '0;
      idx   <= '0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      tick  <= 1'b0;
    end else begin
      s1   <= bus.divclock;
      s2   <= s1;
      s3   <= s2;
      tick <= 1'b0;
      // Disable overrides a coincident rise, so the held index is shown again on re-enable.
      if (!bus.enable) begin
        state <= BLANK;
        bcnt  <= '0;
      end else begin
        case (state)
          BLANK: begin
            if (bcnt == BW'(BLANK_CYCLES - 1)) begin
              state <= SHOW;
              bcnt  <= '0;
              tick  <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          SHOW: begin
            if (rise) begin
              state <= BLANK;
              bcnt  <= '0;
              idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
          end
          default: state <= BLANK;
        endcase
      end
    end
  end

  assign nib = bus.digits[{idx, 2'b00} +: 4];

  always_comb begin
    an_c  = '1;
    seg_c = 7'h7F;
    dp_c  = 1'b1;
    if (state == SHOW) begin
      an_c  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
      seg_c = hexdecode(nib);
      dp_c  = ~bus.dp_mask[idx];
    end
  end

  assign bus.an        = an_c;
  assign bus.seg       = seg_c;
  assign bus.dp        = dp_c;
  assign bus.digit_idx = idx;
  assign bus.scan_tick = tick;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - scoreboard bench for display_scan_driver
module tb_display_scan_driver;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   ticks = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  display_scan_driver_if #(.NUM_DIGITS(4), .IDX_W(2)) bus ();

  display_scan_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(4), .IDX_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int i);
    logic [3:0] one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_show(input int i);
    exp_t e;
    e.idx = i[1:0];
    e.an  = an_of(i);
    e.seg = segtab[bus.digits[4*i +: 4]];
    e.dp  = ~bus.dp_mask[i];
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.scan_tick) begin
      ticks++;
      if (q.size() == 0) begin
        check("tick_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_idx", bus.digit_idx, e.idx);
        check("sb_an",  bus.an,        e.an);
        check("sb_seg", bus.seg,       e.seg);
        check("sb_dp",  bus.dp,        e.dp);
      end
    end
  end

  // Single-cycle divclock pulse first sampled at edge k; new digit expected on screen at k+6.
  task automatic advance(input int nidx);
    bus.divclock = 1'b1;
    expect_show(nidx);
    step();
    bus.divclock = 1'b0;
    step();
    check("still_show_idx", bus.digit_idx, (nidx + 3) % 4);
    step();
    check("blank_idx", bus.digit_idx, nidx);
    check("blank_an",  bus.an, 4'hF);
    repeat (3) step();
    check("blank_end_an", bus.an, 4'hF);
    step();
    check("show_an",   bus.an, an_of(nidx));
    check("show_seg",  bus.seg, segtab[bus.digits[4*nidx +: 4]]);
    check("show_tick", bus.scan_tick, 1);
    step();
    check("tick_once", bus.scan_tick, 0);
    repeat (3) step();
  endtask

  initial begin
    int t0;
    reset        = 1'b1;
    bus.divclock = 1'b0;
    bus.enable   = 1'b1;
    bus.digits   = 16'h4321;
    bus.dp_mask  = 4'b0000;
    repeat (3) step();
    check("rst_an",   bus.an, 4'hF);
    check("rst_seg",  bus.seg, 7'h7F);
    check("rst_dp",   bus.dp, 1);
    check("rst_idx",  bus.digit_idx, 0);
    check("rst_tick", bus.scan_tick, 0);

    reset = 1'b0;
    expect_show(0);
    repeat (3) step();
    check("t1_blank_an", bus.an, 4'hF);
    step();
    check("t1_show_an",  bus.an, 4'b1110);
    check("t1_show_seg", bus.seg, 7'b1111001);
    check("t1_tick",     bus.scan_tick, 1);
    step();
    check("t1_tick_off", bus.scan_tick, 0);
    repeat (4) step();

    t0 = ticks;
    advance(1);
    check("t2_an",  bus.an, 4'b1101);
    check("t2_seg", bus.seg, 7'b0100100);
    advance(2);
    advance(3);
    advance(0);
    check("t3_wrap_an", bus.an, 4'b1110);
    check("t3_ticks", ticks - t0, 4);

    // Second pulse lands while BLANK and must be ignored.
    bus.divclock = 1'b1;
    expect_show(1);
    step();
    bus.divclock = 1'b0;
    step();
    bus.divclock = 1'b1;
    step();
    check("t4_blank_idx", bus.digit_idx, 1);
    check("t4_blank_an",  bus.an, 4'hF);
    bus.divclock = 1'b0;
    repeat (3) step();
    check("t4_dropped_idx", bus.digit_idx, 1);
    check("t4_still_blank", bus.an, 4'hF);
    step();
    check("t4_show_an",  bus.an, 4'b1101);
    check("t4_show_idx", bus.digit_idx, 1);
    repeat (6) step();

    advance(2);
    bus.enable = 1'b0;
    step();
    check("t5_dark_an", bus.an, 4'hF);
    repeat (2) begin
      bus.divclock = 1'b1;
      step();
      bus.divclock = 1'b0;
      repeat (5) step();
    end
    check("t5_held_idx", bus.digit_idx, 2);
    check("t5_dark_seg", bus.seg, 7'h7F);
    bus.enable = 1'b1;
    expect_show(2);
    repeat (3) step();
    check("t5_reen_blank", bus.an, 4'hF);
    step();
    check("t5_reen_an",  bus.an, 4'b1011);
    check("t5_reen_idx", bus.digit_idx, 2);
    repeat (4) step();

    bus.dp_mask = 4'b0001;
    advance(3);
    advance(0);
    for (int v = 0; v < 16; v++) begin
      bus.digits[3:0] = v[3:0];
      #1;
      check("t6_seg", bus.seg, segtab[v]);
      check("t6_dp",  bus.dp, 0);
      step();
    end
    reset = 1'b1;
    step();
    check("t6_rst_an",  bus.an, 4'hF);
    check("t6_rst_seg", bus.seg, 7'h7F);
    check("t6_rst_idx", bus.digit_idx, 0);
    check("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
